// File: rtl/polyadd_seq.sv
// rtl/polyadd_seq.sv - sequencer streaming coefficient pairs through ADDmod into a result memory

// Modular adder: R = A+B-P when A+B >= P, else A+B; operands assumed < P
module ADDmod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] R
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // One conditional subtraction over a WIDTH+1-bit sum so the carry is never lost
  always_comb begin
    w_sum  = {1'b0, A} + {1'b0, B};
    w_diff = w_sum - {1'b0, P};
    R      = (w_sum >= {1'b0, P}) ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
  end
endmodule

module polyadd_seq #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [WIDTH-1:0]  p,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] r_base,
  output logic              busy,
  output logic              done,
  output logic              a_en,
  output logic              b_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  a_rdata,
  input  logic [WIDTH-1:0]  b_rdata,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [WIDTH-1:0]  r_wdata
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_i;       // index of the read issued this cycle
  logic [WIDTH-1:0]  r_p;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [ADDR_W-1:0] r_r_base;
  logic              r_v1;      // read data is arriving this cycle
  logic [ADDR_W-1:0] r_i1;      // index of the data arriving this cycle

  logic [ADDR_W:0]   w_next_i;
  logic              w_last;
  logic [WIDTH-1:0]  w_sum;

  assign w_next_i = r_i + (ADDR_W+1)'(1);
  assign w_last   = (r_i == r_len - (ADDR_W+1)'(1));

  ADDmod #(.WIDTH(WIDTH)) u_addmod (
    .A (a_rdata),
    .B (b_rdata),
    .P (r_p),
    .R (w_sum)
  );

  // Control FSM plus the two-stage read-to-write pipeline; every output is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_i      <= '0;
      r_p      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_r_base <= '0;
      r_v1     <= 1'b0;
      r_i1     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_en     <= 1'b0;
      b_en     <= 1'b0;
      a_addr   <= '0;
      b_addr   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_v1 <= a_en;
      r_i1 <= r_i[ADDR_W-1:0];
      r_we <= r_v1;
      if (r_v1) begin
        r_addr  <= r_r_base + r_i1;
        r_wdata <= w_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= len;
            r_p      <= p;
            r_a_base <= a_base;
            r_b_base <= b_base;
            r_r_base <= r_base;
            r_i      <= '0;
            if (len == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              a_en    <= 1'b1;
              b_en    <= 1'b1;
              a_addr  <= a_base;
              b_addr  <= b_base;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            a_en    <= 1'b0;
            b_en    <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_i    <= w_next_i;
            a_addr <= r_a_base + w_next_i[ADDR_W-1:0];
            b_addr <= r_b_base + w_next_i[ADDR_W-1:0];
          end
        end
        S_DRAIN: begin
          // The last write is the one with nothing behind it in the pipeline
          if (r_we && !r_v1) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_polyadd_seq.sv
// tb/tb_polyadd_seq.sv - scoreboard testbench for polyadd_seq
`timescale 1ns/1ps
module tb_polyadd_seq;
  localparam int W   = 32;
  localparam int AW  = 10;
  localparam int AW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst = 1'b1, start = 1'b0, start4 = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW4:0]  len4 = '0;
  logic [W-1:0]  p = '0, p4 = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, r_base = '0;
  logic [AW4-1:0] a_base4 = '0, b_base4 = '0, r_base4 = '0;
  logic          busy, done, a_en, b_en, r_we;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  logic [W-1:0]  a_rdata = '0, b_rdata = '0, r_wdata;
  logic          busy4, done4, a_en4, b_en4, r_we4;
  logic [AW4-1:0] a_addr4, b_addr4, r_addr4;
  logic [W-1:0]  a_rdata4 = '0, b_rdata4 = '0, r_wdata4;

  polyadd_seq #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p(p),
    .a_base(a_base), .b_base(b_base), .r_base(r_base),
    .busy(busy), .done(done), .a_en(a_en), .b_en(b_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata));

  polyadd_seq #(.WIDTH(W), .ADDR_W(AW4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .len(len4), .p(p4),
    .a_base(a_base4), .b_base(b_base4), .r_base(r_base4),
    .busy(busy4), .done(done4), .a_en(a_en4), .b_en(b_en4),
    .a_addr(a_addr4), .b_addr(b_addr4), .a_rdata(a_rdata4), .b_rdata(b_rdata4),
    .r_we(r_we4), .r_addr(r_addr4), .r_wdata(r_wdata4));

  logic [W-1:0] mem  [0:(1<<AW)-1];
  logic [W-1:0] mem4 [0:(1<<AW4)-1];

  always @(posedge clk) begin
    if (a_en) a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
    if (r_we) mem[r_addr] <= r_wdata;
    if (a_en4) a_rdata4 <= mem4[a_addr4];
    if (b_en4) b_rdata4 <= mem4[b_addr4];
    if (r_we4) mem4[r_addr4] <= r_wdata4;
  end

  int n_cmp = 0, n_err = 0;
  logic [AW-1:0]  qa[$];
  logic [W-1:0]   qd[$];
  logic [AW4-1:0] qa4[$];
  logic [W-1:0]   qd4[$];
  int n_aen, n_we, n_busy, n_done, first_we, last_we, first_busy, first_done, last_done;
  int n4_we, first4_we, last4_we, n4_done, first4_done;

  always @(negedge clk) begin
    logic [AW-1:0]  ea;
    logic [W-1:0]   ed;
    logic [AW4-1:0] ea4;
    if (a_en || b_en) begin
      n_cmp++;
      if (a_en !== b_en) begin n_err++; $display("FAIL en_match a_en=%b b_en=%b cyc=%0d", a_en, b_en, cyc); end
    end
    if (a_en) n_aen++;
    if (busy) begin n_busy++; if (first_busy < 0) first_busy = cyc; end
    if (done) begin n_done++; if (first_done < 0) first_done = cyc; last_done = cyc; end
    if (r_we) begin
      n_we++; if (first_we < 0) first_we = cyc; last_we = cyc;
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++; $display("FAIL sb_extra write addr=%0d data=%h expected none", r_addr, r_wdata);
      end else begin
        ea = qa.pop_front(); ed = qd.pop_front();
        if (r_addr !== ea || r_wdata !== ed) begin
          n_err++; $display("FAIL sb_write got addr=%0d data=%h expected addr=%0d data=%h", r_addr, r_wdata, ea, ed);
        end
      end
    end
    if (done4) begin n4_done++; if (first4_done < 0) first4_done = cyc; end
    if (r_we4) begin
      n4_we++; if (first4_we < 0) first4_we = cyc; last4_we = cyc;
      n_cmp++;
      if (qa4.size() == 0) begin
        n_err++; $display("FAIL sb4_extra write addr=%0d data=%h expected none", r_addr4, r_wdata4);
      end else begin
        ea4 = qa4.pop_front(); ed = qd4.pop_front();
        if (r_addr4 !== ea4 || r_wdata4 !== ed) begin
          n_err++; $display("FAIL sb4_write got addr=%0d data=%h expected addr=%0d data=%h", r_addr4, r_wdata4, ea4, ed);
        end
      end
    end
  end

  function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] pp);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, pp}) s = s - {1'b0, pp};
    return s[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    n_aen = 0; n_we = 0; n_busy = 0; n_done = 0;
    first_we = -1; last_we = -1; first_busy = -1; first_done = -1; last_done = -1;
    n4_we = 0; first4_we = -1; last4_we = -1; n4_done = 0; first4_done = -1;
  endtask

  task automatic push_run(input int L, input int ab, input int bb, input int rb, input logic [W-1:0] pp);
    for (int i = 0; i < L; i++) begin
      qa.push_back(AW'(rb + i));
      qd.push_back(madd(mem[AW'(ab + i)], mem[AW'(bb + i)], pp));
    end
  endtask

  task automatic go(input int L, input logic [W-1:0] pp, input int ab, input int bb, input int rb, output int t);
    len = (AW+1)'(L); p = pp; a_base = AW'(ab); b_base = AW'(bb); r_base = AW'(rb);
    start = 1'b1; t = cyc; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, input string name);
    int c;
    c = 0;
    while (n_done < k && c < budget) begin tick(); c++; end
    if (n_done < k) begin n_cmp++; n_err++; $display("FAIL %s_timeout done_count=%0d expected %0d", name, n_done, k); end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    n_cmp++;
    if ({busy, done, a_en, b_en, r_we} !== 5'b0) begin n_err++; $display("FAIL reset_strobes got %b expected 00000", {busy, done, a_en, b_en, r_we}); end
    n_cmp++;
    if ({a_addr, b_addr, r_addr, r_wdata} !== '0) begin n_err++; $display("FAIL reset_values got %h expected 0", {a_addr, b_addr, r_addr, r_wdata}); end
    n_cmp++;
    if ({busy4, done4, a_en4, r_we4, r_addr4, r_wdata4} !== '0) begin n_err++; $display("FAIL reset_dut4 got %h expected 0", {busy4, done4, a_en4, r_we4, r_addr4, r_wdata4}); end
    rst = 1'b0; tick();
  endtask

  task automatic test_single();
    int t;
    mem[100] = 32'hFBB01FF2; mem[300] = 32'hFBB01F32;
    qa.push_back(AW'(600)); qd.push_back(32'hFBB01F31);
    clr(); go(1, 32'hFBB01FF3, 100, 300, 600, t); wait_done(1, 50, "single");
    n_cmp++; if (first_we != t + 3 || n_we != 1) begin n_err++; $display("FAIL single_we first=%0d n=%0d expected first=%0d n=1", first_we, n_we, t + 3); end
    n_cmp++; if (first_done != t + 4 || n_done != 1) begin n_err++; $display("FAIL single_done cyc=%0d n=%0d expected cyc=%0d n=1", first_done, n_done, t + 4); end
    n_cmp++; if (qa.size() != 0) begin n_err++; $display("FAIL single_sb_left %0d expected 0", qa.size()); end
  endtask

  task automatic test_vector();
    int t;
    for (int i = 0; i < 4; i++) begin mem[100 + i] = i; mem[300 + i] = 2 * i; end
    for (int i = 0; i < 4; i++) begin qa.push_back(AW'(600 + i)); qd.push_back(32'(3 * i)); end
    clr(); go(4, 32'hF0001E1E, 100, 300, 600, t); wait_done(1, 50, "vector");
    n_cmp++; if (n_busy != 6 || first_busy != t + 1) begin n_err++; $display("FAIL vector_busy n=%0d first=%0d expected n=6 first=%0d", n_busy, first_busy, t + 1); end
    n_cmp++; if (first_we != t + 3 || last_we != t + 6 || n_we != 4) begin n_err++; $display("FAIL vector_we first=%0d last=%0d n=%0d expected %0d..%0d n=4", first_we, last_we, n_we, t + 3, t + 6); end
    n_cmp++; if (first_done != t + 7) begin n_err++; $display("FAIL vector_done cyc=%0d expected %0d", first_done, t + 7); end
    n_cmp++; if (n_aen != 4) begin n_err++; $display("FAIL vector_aen n=%0d expected 4", n_aen); end
  endtask

  task automatic test_wrap();
    int t, c;
    logic [W-1:0] m [0:15];
    logic [W-1:0] res [0:15];
    p4 = 32'hC000_0001;
    for (int i = 0; i < 16; i++) begin mem4[i] = $urandom % p4; m[i] = mem4[i]; end
    for (int j = 0; j < 16; j++) begin
      if (j >= 3) m[(14 + j - 3) % 16] = res[j - 3];
      res[j] = madd(m[j], m[j], p4);
      qa4.push_back(AW4'(14 + j)); qd4.push_back(res[j]);
    end
    m[(14 + 13) % 16] = res[13]; m[(14 + 14) % 16] = res[14]; m[(14 + 15) % 16] = res[15];
    clr();
    len4 = 5'd16; a_base4 = 4'd0; b_base4 = 4'd0; r_base4 = 4'd14;
    start4 = 1'b1; t = cyc; tick(); start4 = 1'b0;
    c = 0; while (n4_done < 1 && c < 100) begin tick(); c++; end
    repeat (3) tick();
    n_cmp++; if (n4_we != 16 || first4_we != t + 3 || last4_we != t + 18) begin n_err++; $display("FAIL wrap_we n=%0d first=%0d last=%0d expected n=16 %0d..%0d", n4_we, first4_we, last4_we, t + 3, t + 18); end
    n_cmp++; if (first4_done != t + 19 || n4_done != 1) begin n_err++; $display("FAIL wrap_done cyc=%0d n=%0d expected %0d n=1", first4_done, n4_done, t + 19); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (mem4[i] !== m[i]) begin n_err++; $display("FAIL wrap_mem[%0d] got %h expected %h", i, mem4[i], m[i]); end
    end
  endtask

  task automatic test_zero_and_hold();
    int t;
    clr(); go(0, 32'h1000, 100, 300, 600, t); repeat (4) tick();
    n_cmp++; if (first_done != t + 1 || n_done != 1) begin n_err++; $display("FAIL zero_done cyc=%0d n=%0d expected %0d n=1", first_done, n_done, t + 1); end
    n_cmp++; if (n_aen != 0 || n_we != 0 || n_busy != 0) begin n_err++; $display("FAIL zero_strobes aen=%0d we=%0d busy=%0d expected 0", n_aen, n_we, n_busy); end
    for (int i = 0; i < 8; i++) begin mem[120 + i] = $urandom % 32'h7000_0000; mem[320 + i] = $urandom % 32'h7000_0000; end
    push_run(8, 120, 320, 620, 32'h7000_0000);
    push_run(8, 120, 320, 620, 32'h7000_0000);
    clr();
    len = 11'd8; p = 32'h7000_0000; a_base = 10'd120; b_base = 10'd320; r_base = 10'd620;
    start = 1'b1; t = cyc; repeat (13) tick(); start = 1'b0;
    wait_done(2, 100, "hold");
    n_cmp++; if (n_done != 2 || first_done != t + 11 || last_done != t + 23) begin n_err++; $display("FAIL hold_done n=%0d first=%0d last=%0d expected n=2 %0d,%0d", n_done, first_done, last_done, t + 11, t + 23); end
    n_cmp++; if (n_aen != 16 || n_we != 16 || n_busy != 20) begin n_err++; $display("FAIL hold_counts aen=%0d we=%0d busy=%0d expected 16,16,20", n_aen, n_we, n_busy); end
    n_cmp++; if (qa.size() != 0) begin n_err++; $display("FAIL hold_sb_left %0d expected 0", qa.size()); end
  endtask

  task automatic test_inplace();
    int t;
    logic [W-1:0] pp;
    logic [W-1:0] ex [0:7];
    pp = $urandom | 32'h8000_0000;
    for (int i = 0; i < 8; i++) begin
      mem[200 + i] = 1 + $urandom % (pp - 1);
      mem[400 + i] = $urandom % pp;
    end
    mem[400] = pp - mem[200]; mem[403] = pp - mem[203];
    mem[205] = pp - 1; mem[405] = pp - 1;
    for (int i = 0; i < 8; i++) ex[i] = madd(mem[200 + i], mem[400 + i], pp);
    push_run(8, 200, 400, 200, pp);
    clr(); go(8, pp, 200, 400, 200, t); wait_done(1, 50, "inplace");
    n_cmp++; if (ex[0] !== 32'd0 || ex[3] !== 32'd0 || ex[5] !== pp - 2) begin n_err++; $display("FAIL inplace_model e0=%h e3=%h e5=%h expected 0,0,%h", ex[0], ex[3], ex[5], pp - 2); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (mem[200 + i] !== ex[i]) begin n_err++; $display("FAIL inplace_mem[%0d] got %h expected %h", i, mem[200 + i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [W-1:0] e0, e1;
    for (int i = 0; i < 32; i++) begin
      mem[400 + i] = $urandom % 32'hE000_0000; mem[500 + i] = $urandom % 32'hE000_0000; mem[700 + i] = 32'hDEAD_0000 + i;
    end
    e0 = madd(mem[400], mem[500], 32'hE000_0000); e1 = madd(mem[401], mem[501], 32'hE000_0000);
    push_run(32, 400, 500, 700, 32'hE000_0000);
    clr(); go(32, 32'hE000_0000, 400, 500, 700, t);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    qa.delete(); qd.delete();
    n_cmp++; if ({busy, done, a_en, b_en, r_we} !== 5'b0) begin n_err++; $display("FAIL midrst_strobes got %b expected 00000 at cyc %0d (T+%0d)", {busy, done, a_en, b_en, r_we}, cyc, cyc - t); end
    n_cmp++; if ({a_addr, b_addr, r_addr, r_wdata} !== '0) begin n_err++; $display("FAIL midrst_values got %h expected 0", {a_addr, b_addr, r_addr, r_wdata}); end
    repeat (5) tick();
    n_cmp++; if (mem[700] !== e0 || mem[701] !== e1) begin n_err++; $display("FAIL midrst_kept got %h,%h expected %h,%h", mem[700], mem[701], e0, e1); end
    n_cmp++; if (mem[702] !== 32'hDEAD_0002) begin n_err++; $display("FAIL midrst_dropped got %h expected dead0002", mem[702]); end
    n_cmp++; if (n_done != 0 || n_we != 2) begin n_err++; $display("FAIL midrst_counts done=%0d we=%0d expected 0,2", n_done, n_we); end
    push_run(4, 400, 500, 800, 32'hE000_0000);
    clr(); go(4, 32'hE000_0000, 400, 500, 800, t); wait_done(1, 50, "after_rst");
    n_cmp++; if (n_we != 4 || first_we != t + 3 || first_done != t + 7) begin n_err++; $display("FAIL after_rst we=%0d first=%0d done=%0d expected 4,%0d,%0d", n_we, first_we, first_done, t + 3, t + 7); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_vector();
    test_wrap();
    test_zero_and_hold();
    test_inplace();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
